// File: rtl/jk_bank_seq_pkg.sv
// Shared op codes, FSM state encoding and the expected-result helper for jk_bank_seq.
// Op encoding puts J in op[1] and K in op[0], so the JK truth table falls out directly.
package jk_bank_seq_pkg;

    localparam int N_DEF  = 4;
    localparam int LW_DEF = 8;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_WAIT  = 2'b10
    } state_e;

    // Final value of one masked flop after L updates; odd = L is odd.
    function automatic logic exp_bit(op_e op, logic snap, logic odd);
        logic r;
        r = snap;
        case (op)
            OP_HOLD:   r = snap;
            OP_CLEAR:  r = 1'b0;
            OP_SET:    r = 1'b1;
            OP_TOGGLE: r = snap ^ odd;
            default:   r = snap;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_bank_seq_if.sv
// Command handshake, j/k drive and bank feedback between host, jk_bank_seq and the flop bank.
// master = host/bench side (drives command and bank feedback), slave = the sequencer.
interface jk_bank_seq_if #(
    parameter int N  = 4,
    parameter int LW = 8
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [N-1:0]  cmd_mask;
    logic [LW-1:0] cmd_len;
    logic          abort;
    logic [N-1:0]  j;
    logic [N-1:0]  k;
    logic [N-1:0]  q_in;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_len, abort, q_in,
        input  cmd_ready, j, k, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_len, abort, q_in,
        output cmd_ready, j, k, busy, done, err
    );
endinterface

// File: rtl/jk_bank_seq_len_counter.sv
// Loadable LW-bit down-counter with zero flag; load wins over decrement, holds at zero.
// Single-cycle update, no backpressure.
module jk_len_counter #(
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [LW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);
    logic [LW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jk_bank_seq.sv
// JK bank command sequencer: drives j/k for L cycles, pulses done L+1 cycles after accept.
// cmd_ready only in IDLE (one command per L+2 cycles); JK_BANK_CHECK_EN adds the result check on err.
module jk_bank_seq
    import jk_bank_seq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int LW = LW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    jk_bank_seq_if.slave bus
);
    state_e        state_q, state_d;
    logic [N-1:0]  j_q, j_d;
    logic [N-1:0]  k_q, k_d;
    logic          accept;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [LW-1:0] len_m1;

    // Length 0 is treated as 1, so both load a count of zero.
    assign len_m1 = bus.cmd_len - LW'(bus.cmd_len != '0);

    jk_len_counter #(.LW(LW)) u_len_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (len_m1),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = S_APPLY;
                    j_d      = {N{bus.cmd_op[1]}} & bus.cmd_mask;
                    k_d      = {N{bus.cmd_op[0]}} & bus.cmd_mask;
                end
            end
            S_APPLY: begin
                // Abort outranks the final count; the bank keeps whatever updates it already took.
                if (bus.abort) begin
                    state_d = S_IDLE;
                    j_d     = '0;
                    k_d     = '0;
                end else if (cnt_zero) begin
                    state_d = S_WAIT;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                j_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_WAIT);
    assign bus.j         = j_q;
    assign bus.k         = k_q;

`ifdef JK_BANK_CHECK_EN
    op_e          op_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] snap_q;
    logic         odd_q;
    logic [N-1:0] exp_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_HOLD;
            mask_q <= '0;
            snap_q <= '0;
            odd_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= op_e'(bus.cmd_op);
            mask_q <= bus.cmd_mask;
            snap_q <= bus.q_in;
            odd_q  <= (bus.cmd_len == '0) | bus.cmd_len[0];
        end
    end

    always_comb begin
        exp_v = snap_q;
        for (int i = 0; i < N; i++) begin
            if (mask_q[i]) begin
                exp_v[i] = exp_bit(op_q, snap_q[i], odd_q);
            end
        end
    end

    // q_in already carries all L updates during WAIT, so the compare is qualified by done.
    assign bus.err = (state_q == S_WAIT) && (bus.q_in != exp_v);
`else
    logic unused_q_in;
    logic unused_accept;
    assign unused_q_in   = ^bus.q_in;
    assign unused_accept = accept;
    assign bus.err       = 1'b0;
`endif

endmodule
